// File: rtl/b2_serial_adder_pkg.sv
// b2_serial_adder_pkg: shared state and mode encodings for the serial adder
package b2_serial_adder_pkg;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;
  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;
endpackage

// File: rtl/b2_serial_adder_fa_cell.sv
// b2_serial_adder_fa_cell: gate-level one-bit full adder
module b2_serial_adder_fa_cell (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  logic p;
  assign p  = a ^ b;
  assign s  = p ^ ci;
  assign co = (a & b) | (ci & p);
endmodule

// File: rtl/b2_serial_adder.sv
// b2_serial_adder: bit-serial W-bit adder/subtractor, one bit per clock LSB first
module b2_serial_adder
  import b2_serial_adder_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clock,
  input  logic         reset_,
  input  logic         start,
  input  logic         sub,
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  input  logic         cin,
  output logic [W-1:0] s,
  output logic         cout,
  output logic         ow,
  output logic         busy,
  output logic         done
);
  localparam int CW = $clog2(W + 1);
  state_t state;
  logic [W-1:0] a, b, acc, acc_n;
  logic [W:0] acc_ext;
  logic [CW-1:0] cnt;
  logic carry, fs, fco, go;
  b2_serial_adder_fa_cell u_fa (.a(a[0]), .b(b[0]), .ci(carry), .s(fs), .co(fco));
  // sum bits enter at the MSB so after W shifts bit 0 sits at the LSB
  assign acc_ext = {fs, acc};
  assign acc_n = acc_ext[W:1];
  assign go = start && (state == IDLE || state == DONE);
  always_ff @(posedge clock) begin
    if (!reset_) begin
      state <= IDLE;
      a <= '0;
      b <= '0;
      acc <= '0;
      cnt <= '0;
      carry <= 1'b0;
      s <= '0;
      cout <= 1'b0;
      ow <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      if (go) begin
        a <= x;
        b <= y ^ {W{sub}};
        carry <= (sub == MODE_SUB) ? 1'b1 : cin;
        cnt <= CW'(W - 1);
        state <= BUSY;
        busy <= 1'b1;
      end else if (state == BUSY) begin
        acc <= acc_n;
        a <= a >> 1;
        b <= b >> 1;
        carry <= fco;
        if (cnt == '0) begin
          state <= DONE;
          busy <= 1'b0;
          done <= 1'b1;
          s <= acc_n;
          cout <= fco;
          ow <= carry ^ fco;
        end else begin
          cnt <= cnt - 1'b1;
        end
      end else begin
        state <= IDLE;
      end
    end
  end
endmodule
